display_scanner: RTL and testbench

Four-digit multiplexed 7-segment driver for the coffee machine front panel. It consumes the two divided square waves from the frequency divider: the ~760 Hz refresh wave and the 1 Hz wave. Both are sampled as levels in the `clk` domain and rising-edge detected. Each refresh edge advances the scan one digit. Each 1 Hz edge toggles a blink phase used to flash selected digits, such as the price or a brew countdown.

---
 rtl/display_scanner.sv | 149 ++++++++++++++
 tb/tb_display_scanner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - four-digit multiplexed 7-segment scan driver
//
// Purpose: steps a 4-digit common-anode display one digit per rising edge of
// the refresh wave, flashing digits selected by blink_mask on a phase that
// toggles on each rising edge of the 1 Hz wave, with optional leading-zero
// blanking.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   refresh_in in   refresh square wave (level, clk domain)
//   second_in  in   1 Hz square wave (level, clk domain)
//   digits     in   four hex nibbles, digits[3:0] is the rightmost digit
//   blink_mask in   bit i set: digit i flashes
//   dp_mask    in   bit i set: decimal point of digit i lit
//   an         out  anode enables, active-low
//   seg        out  segments {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low
module display_scanner #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refresh_in,
  input  logic        second_in,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_e;

  scan_e       state_q, state_d, scan_next;
  logic        ref_q, sec_q;
  logic        phase_q, phase_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        ref_rise, sec_rise;
  logic [1:0]  n;
  logic [3:0]  nibble;
  logic        hi_zero;
  logic        blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign ref_rise = refresh_in & ~ref_q;
  assign sec_rise = second_in & ~sec_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q ^ sec_rise;
    an_d      = an_q;
    seg_d     = seg_q;
    dp_d      = dp_q;
    scan_next = DIG0;
    nibble    = 4'h0;
    hi_zero   = 1'b0;

    case (state_q)
      DIG0: scan_next = DIG1;
      DIG1: scan_next = DIG2;
      DIG2: scan_next = DIG3;
      DIG3: scan_next = DIG0;
      default: scan_next = DIG0;
    endcase
    n = scan_next;

    // hi_zero: this nibble and every nibble to its left are zero; digit 0
    // is never a leading zero.
    case (scan_next)
      DIG0: begin nibble = digits[3:0];   hi_zero = 1'b0;                  end
      DIG1: begin nibble = digits[7:4];   hi_zero = (digits[15:4] == '0);  end
      DIG2: begin nibble = digits[11:8];  hi_zero = (digits[15:8] == '0);  end
      DIG3: begin nibble = digits[15:12]; hi_zero = (digits[15:12] == '0); end
      default: begin nibble = 4'h0; hi_zero = 1'b0; end
    endcase

    // Uses the post-toggle phase so a simultaneous 1 Hz edge takes effect
    // on the digit being loaded now.
    blank = (phase_d & blink_mask[n]) | (BLANK_LEADING & hi_zero);

    if (ref_rise) begin
      state_d = scan_next;
      if (blank) begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
      end else begin
        an_d  = ~(4'b0001 << n);
        seg_d = hex7(nibble);
        dp_d  = ~dp_mask[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    // Edge-detect registers follow the inputs even in reset so that a level
    // already high at release is not seen as a rising edge.
    ref_q <= refresh_in;
    sec_q <= second_in;
    if (rst) begin
      state_q <= DIG0;
      phase_q <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - self-checking bench for display_scanner
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        refresh_in;
  logic        second_in;
  logic [15:0] digits;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  display_scanner #(.BLANK_LEADING(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .refresh_in (refresh_in),
    .second_in  (second_in),
    .digits     (digits),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks scan position and blink phase as integers and
  // derives the displayed digit from the rules directly.
  bit         seen_rst = 1'b0;
  bit         prev_r, prev_s, r_edge, s_edge;
  int         m_idx;
  bit         m_phase;
  logic [3:0] e_an  = 4'b1111;
  logic [6:0] e_seg = 7'b1111111;
  logic       e_dp  = 1'b1;
  int         nib;
  bit         lead, dark;

  always @(posedge clk) begin
    if (rst) begin
      seen_rst = 1'b1;
      prev_r   = refresh_in;
      prev_s   = second_in;
      m_idx    = 0;
      m_phase  = 1'b0;
      e_an     = 4'b1111;
      e_seg    = 7'b1111111;
      e_dp     = 1'b1;
    end else if (seen_rst) begin
      r_edge = refresh_in && !prev_r;
      s_edge = second_in && !prev_s;
      prev_r = refresh_in;
      prev_s = second_in;
      if (s_edge) m_phase = !m_phase;
      if (r_edge) begin
        m_idx = (m_idx + 1) % 4;
        nib   = (int'(digits) >> (4 * m_idx)) & 15;
        lead  = (m_idx != 0) && ((int'(digits) >> (4 * m_idx)) == 0);
        dark  = (m_phase && blink_mask[m_idx]) || lead;
        if (dark) begin
          e_an  = 4'b1111;
          e_seg = 7'b1111111;
          e_dp  = 1'b1;
        end else begin
          e_an  = 4'(15 - (1 << m_idx));
          e_seg = HEX[nib];
          e_dp  = !dp_mask[m_idx];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (seen_rst) begin
      check("model_an", {3'b0, an}, {3'b0, e_an});
      check("model_seg", seg, e_seg);
      check("model_dp", {6'b0, dp}, {6'b0, e_dp});
    end
  end

  task automatic step();
    refresh_in = 1'b1;
    @(negedge clk);
    refresh_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic sec_pulse();
    second_in = 1'b1;
    @(negedge clk);
    second_in = 1'b0;
    @(negedge clk);
  endtask

  logic [3:0] x_an  [4];
  logic [6:0] x_seg [4];

  initial begin
    rst = 1'b1; refresh_in = 1'b0; second_in = 1'b0;
    digits = 16'h0; blink_mask = 4'h0; dp_mask = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_an", {3'b0, an}, 7'b0001111);
    check("reset_seg", seg, 7'b1111111);
    check("reset_dp", {6'b0, dp}, 7'b0000001);
    rst = 1'b0;
    @(negedge clk);
    check("dark_before_refresh", {3'b0, an}, 7'b0001111);

    digits = 16'h1234;
    x_an  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    x_seg = '{7'b0110000, 7'b0100100, 7'b1111001, 7'b0011001};
    for (int i = 0; i < 4; i++) begin
      step();
      check("h1234_an", {3'b0, an}, {3'b0, x_an[i]});
      check("h1234_seg", seg, x_seg[i]);
      check("h1234_dp", {6'b0, dp}, 7'b0000001);
    end

    digits = 16'h0050;
    x_an  = '{4'b1101, 4'b1111, 4'b1111, 4'b1110};
    x_seg = '{7'b0010010, 7'b1111111, 7'b1111111, 7'b1000000};
    for (int i = 0; i < 4; i++) begin
      step();
      check("lead_an", {3'b0, an}, {3'b0, x_an[i]});
      check("lead_seg", seg, x_seg[i]);
    end

    digits = 16'h1234; blink_mask = 4'b0001; dp_mask = 4'b0100;
    sec_pulse();
    step();
    check("blink_d1_an", {3'b0, an}, 7'b0001101);
    check("blink_d1_dp", {6'b0, dp}, 7'b0000001);
    step();
    check("blink_d2_an", {3'b0, an}, 7'b0001011);
    check("blink_d2_dp", {6'b0, dp}, 7'b0000000);
    step();
    check("blink_d3_an", {3'b0, an}, 7'b0000111);
    step();
    check("blink_d0_dark", {3'b0, an}, 7'b0001111);
    check("blink_d0_seg", seg, 7'b1111111);
    sec_pulse();
    repeat (4) step();
    check("unblink_d0_an", {3'b0, an}, 7'b0001110);
    check("unblink_d0_seg", seg, 7'b0011001);

    repeat (3) step();
    refresh_in = 1'b1; second_in = 1'b1;
    @(negedge clk);
    check("simul_dark_an", {3'b0, an}, 7'b0001111);
    check("simul_dark_dp", {6'b0, dp}, 7'b0000001);
    refresh_in = 1'b0; second_in = 1'b0;
    @(negedge clk);

    refresh_in = 1'b1;
    @(negedge clk);
    check("held_first_an", {3'b0, an}, 7'b0001101);
    check("held_first_seg", seg, 7'b0110000);
    repeat (100) @(negedge clk);
    check("held_one_step_an", {3'b0, an}, 7'b0001101);

    rst = 1'b1;
    @(negedge clk);
    check("midrst_an", {3'b0, an}, 7'b0001111);
    check("midrst_seg", seg, 7'b1111111);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rel_high_no_step", {3'b0, an}, 7'b0001111);
    refresh_in = 1'b0;
    @(negedge clk);
    refresh_in = 1'b1;
    @(negedge clk);
    check("rel_restart_an", {3'b0, an}, 7'b0001101);
    check("rel_restart_seg", seg, 7'b0110000);
    refresh_in = 1'b0;
    @(negedge clk);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) refresh_in = ~refresh_in;
      if ($urandom_range(0, 19) == 0) second_in = ~second_in;
      if ($urandom_range(0, 49) == 0) begin
        for (int k = 0; k < 4; k++)
          digits[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        blink_mask = 4'($urandom_range(0, 15));
        dp_mask    = 4'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
